ex_stage: RTL and testbench

// Execute stage of the 5-stage RV32I pipeline, directly upstream of MEM.
// - Takes one decoded instruction from ID (give/get handshake), computes ALU result, load/store address or link value.
// - Resolves branches and jumps, then hands instr/result/rs2 to MEM.
// - Shifts are iterative, one bit per cycle, so the stage is multi-cycle for SLL/SRL/SRA.
//

---
 rtl/ex_if.sv | 27 ++
 rtl/ex_stage.sv | 103 ++++++++++
 tb/tb_ex_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_if.sv
// ex_if: ID->EX and EX->MEM handshake bundle with redirect outputs
interface ex_if #(
  parameter int BITSIZE = 32
);
  logic               ID_EX_give_i;
  logic               EX_ID_get_o;
  logic [31:0]        ID_EX_instr_i;
  logic [BITSIZE-1:0] ID_EX_pc_i;
  logic [BITSIZE-1:0] ID_EX_rs1_i;
  logic [BITSIZE-1:0] ID_EX_rs2_i;
  logic [BITSIZE-1:0] ID_EX_imm_i;
  logic               MEM_EX_get_i;
  logic               EX_MEM_give_o;
  logic [31:0]        EX_MEM_instr_o;
  logic [BITSIZE-1:0] EX_MEM_result_o;
  logic [BITSIZE-1:0] EX_MEM_rs2_o;
  logic               EX_branch_o;
  logic [BITSIZE-1:0] EX_branch_target_o;
  modport slave (
    input  ID_EX_give_i, ID_EX_instr_i, ID_EX_pc_i, ID_EX_rs1_i, ID_EX_rs2_i, ID_EX_imm_i, MEM_EX_get_i,
    output EX_ID_get_o, EX_MEM_give_o, EX_MEM_instr_o, EX_MEM_result_o, EX_MEM_rs2_o, EX_branch_o, EX_branch_target_o
  );
  modport master (
    output ID_EX_give_i, ID_EX_instr_i, ID_EX_pc_i, ID_EX_rs1_i, ID_EX_rs2_i, ID_EX_imm_i, MEM_EX_get_i,
    input  EX_ID_get_o, EX_MEM_give_o, EX_MEM_instr_o, EX_MEM_result_o, EX_MEM_rs2_o, EX_branch_o, EX_branch_target_o
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with bit-serial shifter and branch/jump resolution
module ex_stage #(
  parameter int BITSIZE = 32
) (
  input logic clk,
  input logic resetn_i,
  ex_if.slave bus
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
    OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_BR = 7'b1100011;
  typedef enum logic [1:0] {GET_INSTR, SHIFT, PROVIDE_DATA} state_t;
  state_t state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [BITSIZE-1:0] result_q, result_d, rs2_q, rs2_d, target_q, target_d;
  logic [BITSIZE-1:0] a, r2, b, alu, addr, res_new;
  logic [4:0] cnt_q, cnt_d;
  logic redir_q, redir_d, taken, give, is_alu, is_shift;
  logic [6:0] op;
  logic [2:0] f3;
  assign op = bus.ID_EX_instr_i[6:0];
  assign f3 = bus.ID_EX_instr_i[14:12];
  assign a = bus.ID_EX_rs1_i;
  assign r2 = bus.ID_EX_rs2_i;
  assign b = op == OP_R ? r2 : bus.ID_EX_imm_i;
  assign addr = a + bus.ID_EX_imm_i;
  assign is_alu = op == OP_R || op == OP_I;
  assign is_shift = is_alu && f3[1:0] == 2'b01 && b[4:0] != 5'd0;
  assign give = state_q == PROVIDE_DATA && bus.MEM_EX_get_i;
  always_comb begin
    case (f3)
      3'b000:  alu = op == OP_R && bus.ID_EX_instr_i[30] ? a - b : a + b;
      3'b010:  alu = BITSIZE'($signed(a) < $signed(b));
      3'b011:  alu = BITSIZE'(a < b);
      3'b100:  alu = a ^ b;
      3'b110:  alu = a | b;
      3'b111:  alu = a & b;
      default: alu = a;
    endcase
  end
  assign taken = f3 == 3'b000 ? a == r2 :
                 f3 == 3'b001 ? a != r2 :
                 f3 == 3'b100 ? $signed(a) < $signed(r2) :
                 f3 == 3'b101 ? $signed(a) >= $signed(r2) :
                 f3 == 3'b110 ? a < r2 :
                 f3 == 3'b111 ? a >= r2 : 1'b0;
  assign res_new = is_alu ? alu :
                   op == OP_LUI ? bus.ID_EX_imm_i :
                   op == OP_AUIPC ? bus.ID_EX_pc_i + bus.ID_EX_imm_i :
                   op == OP_LOAD || op == OP_STORE ? addr :
                   op == OP_JAL || op == OP_JALR ? bus.ID_EX_pc_i + BITSIZE'(4) : '0;
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    result_d = result_q;
    rs2_d = rs2_q;
    target_d = target_q;
    redir_d = redir_q;
    cnt_d = cnt_q;
    if (state_q == GET_INSTR) begin
      if (bus.ID_EX_give_i) begin
        instr_d = bus.ID_EX_instr_i;
        rs2_d = r2;
        result_d = res_new;
        cnt_d = b[4:0];
        redir_d = op == OP_JAL || op == OP_JALR || (op == OP_BR && taken);
        target_d = op == OP_JALR ? {addr[BITSIZE-1:1], 1'b0} : bus.ID_EX_pc_i + bus.ID_EX_imm_i;
        state_d = is_shift ? SHIFT : PROVIDE_DATA;
      end
    end else if (state_q == SHIFT) begin
      result_d = instr_q[14:12] == 3'b001 ? result_q << 1 : {instr_q[30] & result_q[BITSIZE-1], result_q[BITSIZE-1:1]};
      cnt_d = cnt_q - 5'd1;
      state_d = cnt_q == 5'd1 ? PROVIDE_DATA : SHIFT;
    end else begin
      state_d = give ? GET_INSTR : PROVIDE_DATA;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn_i) begin
      state_q <= GET_INSTR;
      instr_q <= '0;
      result_q <= '0;
      rs2_q <= '0;
      target_q <= '0;
      redir_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      result_q <= result_d;
      rs2_q <= rs2_d;
      target_q <= target_d;
      redir_q <= redir_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.EX_ID_get_o = state_q == GET_INSTR;
  assign bus.EX_MEM_give_o = give;
  assign bus.EX_MEM_instr_o = instr_q;
  assign bus.EX_MEM_result_o = result_q;
  assign bus.EX_MEM_rs2_o = rs2_q;
  assign bus.EX_branch_o = give && redir_q;
  assign bus.EX_branch_target_o = give && redir_q ? target_q : '0;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and random checks of ex_stage against an ISA-level reference model
module tb_ex_stage;
  logic clk = 1'b0;
  logic resetn;
  int checks = 0;
  int failures = 0;
  int obs_lat;
  logic [31:0] obs_result, obs_instr, obs_rs2, obs_target;
  logic obs_branch, obs_branch_after, obs_get_after;
  ex_if #(.BITSIZE(32)) bus ();
  ex_stage #(.BITSIZE(32)) dut (.clk(clk), .resetn_i(resetn), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [31:0] ins, pc, rs1, rs2, imm,
                                output logic [31:0] res, output logic redir, output logic [31:0] tgt, output int lat);
    logic [31:0] o;
    int sh;
    logic [2:0] f3;
    logic is_r;
    f3 = ins[14:12];
    is_r = ins[6:0] == 7'b0110011;
    o = is_r ? rs2 : imm;
    sh = int'(o[4:0]);
    res = 0;
    redir = 0;
    tgt = 0;
    lat = 1;
    case (ins[6:0])
      7'b0110011, 7'b0010011:
        case (f3)
          3'd0: res = (is_r && ins[30]) ? rs1 - o : rs1 + o;
          3'd1: begin res = rs1 << sh; lat = 1 + sh; end
          3'd2: res = ($signed(rs1) < $signed(o)) ? 1 : 0;
          3'd3: res = (rs1 < o) ? 1 : 0;
          3'd4: res = rs1 ^ o;
          3'd5: begin res = ins[30] ? 32'($signed(rs1) >>> sh) : rs1 >> sh; lat = 1 + sh; end
          3'd6: res = rs1 | o;
          default: res = rs1 & o;
        endcase
      7'b0110111: res = imm;
      7'b0010111: res = pc + imm;
      7'b0000011, 7'b0100011: res = rs1 + imm;
      7'b1101111: begin res = pc + 4; redir = 1; tgt = pc + imm; end
      7'b1100111: begin res = pc + 4; redir = 1; tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
      7'b1100011: begin
        case (f3)
          3'd0: redir = rs1 == rs2;
          3'd1: redir = rs1 != rs2;
          3'd4: redir = $signed(rs1) < $signed(rs2);
          3'd5: redir = $signed(rs1) >= $signed(rs2);
          3'd6: redir = rs1 < rs2;
          3'd7: redir = rs1 >= rs2;
          default: redir = 0;
        endcase
        tgt = pc + imm;
      end
      default: res = 0;
    endcase
  endfunction
  task automatic drive(input logic [31:0] ins, pc, rs1, rs2, imm);
    bus.ID_EX_give_i = 1'b1;
    bus.ID_EX_instr_i = ins;
    bus.ID_EX_pc_i = pc;
    bus.ID_EX_rs1_i = rs1;
    bus.ID_EX_rs2_i = rs2;
    bus.ID_EX_imm_i = imm;
    @(posedge clk);
    @(negedge clk);
    bus.ID_EX_give_i = 1'b0;
    bus.ID_EX_instr_i = $urandom;
    bus.ID_EX_pc_i = $urandom;
    bus.ID_EX_rs1_i = $urandom;
    bus.ID_EX_rs2_i = $urandom;
    bus.ID_EX_imm_i = $urandom;
  endtask
  task automatic issue(input logic [31:0] ins, pc, rs1, rs2, imm);
    drive(ins, pc, rs1, rs2, imm);
    obs_lat = 1;
    while (!bus.EX_MEM_give_o && obs_lat < 64) begin
      @(negedge clk);
      obs_lat++;
    end
    obs_result = bus.EX_MEM_result_o;
    obs_instr = bus.EX_MEM_instr_o;
    obs_rs2 = bus.EX_MEM_rs2_o;
    obs_branch = bus.EX_branch_o;
    obs_target = bus.EX_branch_target_o;
    @(negedge clk);
    obs_branch_after = bus.EX_branch_o;
    obs_get_after = bus.EX_ID_get_o;
  endtask
  task automatic verify(input string tag, input logic [31:0] ins, pc, rs1, rs2, imm);
    logic [31:0] res, tgt;
    logic redir;
    int lat;
    chk({tag, ".get_idle"}, 32'(bus.EX_ID_get_o), 32'd1);
    model(ins, pc, rs1, rs2, imm, res, redir, tgt, lat);
    issue(ins, pc, rs1, rs2, imm);
    chk({tag, ".latency"}, 32'(obs_lat), 32'(lat));
    chk({tag, ".result"}, obs_result, res);
    chk({tag, ".instr"}, obs_instr, ins);
    chk({tag, ".rs2"}, obs_rs2, rs2);
    chk({tag, ".branch"}, 32'(obs_branch), 32'(redir));
    if (redir) chk({tag, ".target"}, obs_target, tgt);
    chk({tag, ".branch_after"}, 32'(obs_branch_after), 32'd0);
    chk({tag, ".get_after"}, 32'(obs_get_after), 32'd1);
  endtask
  initial begin
    logic [6:0] ops [10];
    logic [31:0] ins, rs1, rs2;
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
            7'b0100011, 7'b1101111, 7'b1100111, 7'b1100011, 7'b1111111};
    resetn = 1'b0;
    bus.MEM_EX_get_i = 1'b1;
    bus.ID_EX_give_i = 1'b0;
    bus.ID_EX_instr_i = '0;
    bus.ID_EX_pc_i = '0;
    bus.ID_EX_rs1_i = '0;
    bus.ID_EX_rs2_i = '0;
    bus.ID_EX_imm_i = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    chk("reset.get", 32'(bus.EX_ID_get_o), 32'd1);
    chk("reset.give", 32'(bus.EX_MEM_give_o), 32'd0);
    chk("reset.branch", 32'(bus.EX_branch_o), 32'd0);
    chk("reset.target", bus.EX_branch_target_o, 32'd0);
    chk("reset.result", bus.EX_MEM_result_o, 32'd0);
    chk("reset.instr", bus.EX_MEM_instr_o, 32'd0);
    verify("addi", 32'h0050_0093, 32'h0, 32'h0, 32'h0, 32'd5);
    chk("addi.lit_result", obs_result, 32'd5);
    chk("addi.lit_lat", 32'(obs_lat), 32'd1);
    verify("sub", {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 32'h0, 32'd3, 32'd5, 32'h0);
    chk("sub.lit_result", obs_result, 32'hFFFF_FFFE);
    verify("sltu", {7'd0, 5'd2, 5'd1, 3'b011, 5'd3, 7'b0110011}, 32'h0, 32'd3, 32'hFFFF_FFFF, 32'h0);
    chk("sltu.lit_result", obs_result, 32'd1);
    verify("srai", {7'b0100000, 5'd4, 5'd1, 3'b101, 5'd2, 7'b0010011}, 32'h0, 32'h8000_0000, 32'h0, 32'd4);
    chk("srai.lit_result", obs_result, 32'hF800_0000);
    chk("srai.lit_lat", 32'(obs_lat), 32'd5);
    verify("slli0", {7'd0, 5'd0, 5'd1, 3'b001, 5'd2, 7'b0010011}, 32'h0, 32'h1234_5678, 32'h0, 32'd0);
    chk("slli0.lit_result", obs_result, 32'h1234_5678);
    chk("slli0.lit_lat", 32'(obs_lat), 32'd1);
    verify("beq", {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011}, 32'h100, 32'd7, 32'd7, 32'hFFFF_FFF8);
    chk("beq.lit_branch", 32'(obs_branch), 32'd1);
    chk("beq.lit_target", obs_target, 32'hF8);
    verify("bne", {7'd0, 5'd2, 5'd1, 3'b001, 5'd0, 7'b1100011}, 32'h100, 32'd7, 32'd7, 32'hFFFF_FFF8);
    chk("bne.lit_branch", 32'(obs_branch), 32'd0);
    verify("jalr", {12'd0, 5'd1, 3'b000, 5'd1, 7'b1100111}, 32'h40, 32'h203, 32'h0, 32'h0);
    chk("jalr.lit_result", obs_result, 32'h44);
    chk("jalr.lit_target", obs_target, 32'h202);
    verify("sw", {7'd0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b0100011}, 32'h0, 32'h1000, 32'hCAFE_BABE, 32'h10);
    chk("sw.lit_result", obs_result, 32'h1010);
    chk("sw.lit_rs2", obs_rs2, 32'hCAFE_BABE);
    bus.MEM_EX_get_i = 1'b0;
    drive({7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011}, 32'h100, 32'd7, 32'd7, 32'hFFFF_FFF8);
    for (int i = 0; i < 10; i++) begin
      chk("stall.get", 32'(bus.EX_ID_get_o), 32'd0);
      chk("stall.give", 32'(bus.EX_MEM_give_o), 32'd0);
      chk("stall.branch", 32'(bus.EX_branch_o), 32'd0);
      chk("stall.instr", bus.EX_MEM_instr_o, {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011});
      chk("stall.rs2", bus.EX_MEM_rs2_o, 32'd7);
      @(negedge clk);
    end
    bus.MEM_EX_get_i = 1'b1;
    #1;
    chk("stall_release.give", 32'(bus.EX_MEM_give_o), 32'd1);
    chk("stall_release.branch", 32'(bus.EX_branch_o), 32'd1);
    chk("stall_release.target", bus.EX_branch_target_o, 32'hF8);
    chk("stall_release.result", bus.EX_MEM_result_o, 32'd0);
    @(negedge clk);
    chk("stall_done.get", 32'(bus.EX_ID_get_o), 32'd1);
    chk("stall_done.branch", 32'(bus.EX_branch_o), 32'd0);
    drive({7'b0100000, 5'd20, 5'd1, 3'b101, 5'd2, 7'b0010011}, 32'h0, 32'h8000_0000, 32'h0, 32'd20);
    repeat (3) @(negedge clk);
    chk("midshift.get", 32'(bus.EX_ID_get_o), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("midreset.get", 32'(bus.EX_ID_get_o), 32'd1);
    chk("midreset.give", 32'(bus.EX_MEM_give_o), 32'd0);
    chk("midreset.result", bus.EX_MEM_result_o, 32'd0);
    chk("midreset.instr", bus.EX_MEM_instr_o, 32'd0);
    verify("addi_after_reset", 32'h0050_0093, 32'h0, 32'h0, 32'h0, 32'd5);
    chk("addi_after_reset.lit_result", obs_result, 32'd5);
    for (int n = 0; n < 60; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      rs1 = $urandom;
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      verify("rand", ins, $urandom & 32'hFFFF_FFFC, rs1, rs2, $urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
